// File: rtl/decode_scoreboard_pkg.sv
// decode_scoreboard_pkg: shared types for the decode-stage hazard scoreboard.
// Holds the FSM state enum, the register index type and the decode request bundle.
package decode_scoreboard_pkg;

    localparam int IDX_W = 5;

    typedef logic [IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_HAZARD,
        SB_ISSUE
    } sb_state_e;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     use_rs1;
        logic     use_rs2;
        logic     wr_rd;
    } sb_req_t;

endpackage

// File: rtl/sb_pend_file.sv
// sb_pend_file: per-register outstanding-write counters (x0 never tracked).
// Ports: clk_i/rst_i, clr_i (flush clear), inc_i/inc_idx_i (issue),
//        dec_i/dec_idx_i (writeback), three combinational read ports.
module sb_pend_file
    import decode_scoreboard_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    input  reg_idx_t          inc_idx_i,
    input  logic              dec_i,
    input  reg_idx_t          dec_idx_i,
    input  reg_idx_t          rs1_idx_i,
    input  reg_idx_t          rs2_idx_i,
    input  reg_idx_t          rd_idx_i,
    output logic [PEND_W-1:0] rs1_cnt_o,
    output logic [PEND_W-1:0] rs2_cnt_o,
    output logic [PEND_W-1:0] rd_cnt_o
);

    logic [PEND_W-1:0] pend_q [NREGS];
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;

    // Decrement of an empty counter is dropped so it cannot wrap.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc_v[r] = inc_i && (inc_idx_i == IDX_W'(r)) && (r != 0);
            dec_v[r] = dec_i && (dec_idx_i == IDX_W'(r)) && (r != 0)
                       && (pend_q[r] != '0);
        end
    end

    // Issue and writeback to the same register cancel out.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int r = 0; r < NREGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (inc_v[r] && !dec_v[r]) begin
                    pend_q[r] <= pend_q[r] + PEND_W'(1);
                end else if (dec_v[r] && !inc_v[r]) begin
                    pend_q[r] <= pend_q[r] - PEND_W'(1);
                end
            end
        end
    end

    assign rs1_cnt_o = pend_q[rs1_idx_i];
    assign rs2_cnt_o = pend_q[rs2_idx_i];
    assign rd_cnt_o  = pend_q[rd_idx_i];

endmodule

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: holds a decoded instruction until its registers are free,
// then issues it to execute. Ports: decode valid/ready + fields, execute
// valid/ready, writeback release (wb_valid_i/wb_rd_i), flush_i, stall_cnt_o.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int PEND_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dec_valid_i,
    output logic        dec_ready_o,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic        use_rs1_i,
    input  logic        use_rs2_i,
    input  logic        wr_rd_i,
    output logic        exe_valid_o,
    input  logic        exe_ready_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        flush_i,
    output logic [31:0] stall_cnt_o
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    sb_state_e         state_q;
    sb_state_e         state_d;
    sb_req_t           req_q;
    sb_req_t           dec_req;
    sb_req_t           chk_req;
    logic [PEND_W-1:0] rs1_cnt;
    logic [PEND_W-1:0] rs2_cnt;
    logic [PEND_W-1:0] rd_cnt;
    logic              hazard;
    logic              issue_inc;
    logic [31:0]       stall_q;

    always_comb begin
        dec_req         = '0;
        dec_req.rs1     = rs1_i;
        dec_req.rs2     = rs2_i;
        dec_req.rd      = rd_i;
        dec_req.use_rs1 = use_rs1_i;
        dec_req.use_rs2 = use_rs2_i;
        dec_req.wr_rd   = wr_rd_i;
    end

    // In IDLE the check looks at the incoming fields so the accept edge
    // already picks HAZARD or ISSUE; afterwards it looks at the held copy.
    assign chk_req = (state_q == SB_IDLE) ? dec_req : req_q;

    assign issue_inc = (state_q == SB_ISSUE) && exe_ready_i
                       && req_q.wr_rd && !flush_i;

    sb_pend_file #(
        .NREGS  (NREGS),
        .PEND_W (PEND_W)
    ) u_pend (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (flush_i),
        .inc_i     (issue_inc),
        .inc_idx_i (req_q.rd),
        .dec_i     (wb_valid_i && !flush_i),
        .dec_idx_i (wb_rd_i),
        .rs1_idx_i (chk_req.rs1),
        .rs2_idx_i (chk_req.rs2),
        .rd_idx_i  (chk_req.rd),
        .rs1_cnt_o (rs1_cnt),
        .rs2_cnt_o (rs2_cnt),
        .rd_cnt_o  (rd_cnt)
    );

    assign hazard = (chk_req.use_rs1 && (rs1_cnt != '0))
                 || (chk_req.use_rs2 && (rs2_cnt != '0))
                 || (chk_req.wr_rd && (chk_req.rd != '0)
                     && (rd_cnt == PEND_MAX));

    always_comb begin
        state_d     = state_q;
        dec_ready_o = 1'b0;
        exe_valid_o = 1'b0;
        unique case (state_q)
            SB_IDLE: begin
                dec_ready_o = 1'b1;
                if (dec_valid_i) begin
                    state_d = hazard ? SB_HAZARD : SB_ISSUE;
                end
            end
            SB_HAZARD: begin
                if (!hazard) begin
                    state_d = SB_ISSUE;
                end
            end
            SB_ISSUE: begin
                exe_valid_o = 1'b1;
                if (exe_ready_i) begin
                    state_d = SB_IDLE;
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SB_IDLE;
            req_q   <= '0;
            stall_q <= '0;
        end else if (flush_i) begin
            state_q <= SB_IDLE;
        end else begin
            state_q <= state_d;
            if (state_q == SB_IDLE && dec_valid_i) begin
                req_q <= dec_req;
            end
            if (state_q == SB_HAZARD) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed stimulus with a queue of expected issues
// checked by an independent monitor, plus direct state checks.
module tb_decode_scoreboard;
    import decode_scoreboard_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dec_valid_i = 1'b0;
    logic        dec_ready_o;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        use_rs1_i = 1'b0;
    logic        use_rs2_i = 1'b0;
    logic        wr_rd_i = 1'b0;
    logic        exe_valid_o;
    logic        exe_ready_i = 1'b1;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] stall_cnt_o;

    decode_scoreboard dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dec_valid_i (dec_valid_i),
        .dec_ready_o (dec_ready_o),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .rd_i        (rd_i),
        .use_rs1_i   (use_rs1_i),
        .use_rs2_i   (use_rs2_i),
        .wr_rd_i     (wr_rd_i),
        .exe_valid_o (exe_valid_o),
        .exe_ready_i (exe_ready_i),
        .wb_valid_i  (wb_valid_i),
        .wb_rd_i     (wb_rd_i),
        .flush_i     (flush_i),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int cyc;
        int stall;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int pend(input int r);
        return int'(dut.u_pend.pend_q[r]);
    endfunction

    // Monitor: every completed execute handshake must match the next
    // expected issue (cycle and stall count at that time).
    always @(negedge clk_i) begin
        if (!rst_i && exe_valid_o && exe_ready_i) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=cycle%0d required=none",
                         cyc);
            end else begin
                e = q.pop_front();
                chk("issue_cycle", cyc, e.cyc);
                chk("issue_stall", stall_cnt_o, e.stall);
            end
        end
    end

    // A writeback must never target a register with nothing outstanding.
    always @(posedge clk_i) begin
        if (!rst_i && !flush_i && wb_valid_i && wb_rd_i != 5'd0) begin
            chk("wb_underflow", pend(int'(wb_rd_i)) == 0 ? 1 : 0, 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int r1, input int r2, input int rd,
                        input bit u1, input bit u2, input bit wr,
                        output int acc_cyc);
        bit acc;
        int n;
        rs1_i       = 5'(r1);
        rs2_i       = 5'(r2);
        rd_i        = 5'(rd);
        use_rs1_i   = u1;
        use_rs2_i   = u2;
        wr_rd_i     = wr;
        dec_valid_i = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = dec_ready_o;
            step(1);
            n++;
        end
        if (!acc) chk("send_timeout", 1, 0);
        dec_valid_i = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wb(input int r);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'(r);
        step(1);
        wb_valid_i = 1'b0;
    endtask

    initial begin
        int a;
        int tot;
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int tot;
        step(2);
        rst_i = 1'b0;
        chk("rst_dec_ready", dec_ready_o, 1);
        chk("rst_exe_valid", exe_valid_o, 0);
        chk("rst_stall", stall_cnt_o, 0);
        chk("rst_pend3", pend(3), 0);

        // No hazard: issue next cycle, pend[3] becomes 1.
        send(1, 2, 3, 1, 1, 1, a);
        q.push_back('{a, 0});
        step(1);
        chk("nohaz_pend3", pend(3), 1);
        chk("nohaz_idle", dec_ready_o, 1);

        // RAW on x5: writeback in 4th hazard cycle, 5 stall cycles.
        send(0, 0, 5, 0, 0, 1, a);
        q.push_back('{a, 0});
        send(5, 0, 0, 1, 0, 0, a);
        q.push_back('{a + 5, 5});
        chk("raw_ready_low", dec_ready_o, 0);
        step(3);
        wb(5);
        step(2);
        chk("raw_pend5", pend(5), 0);

        // x0 never tracked, never stalls.
        for (int i = 0; i < 10; i++) begin
            send(0, 0, 0, 1, 1, 1, a);
            q.push_back('{a, 5});
        end
        step(2);
        tot = 0;
        for (int r = 0; r < 32; r++) tot += pend(r);
        chk("x0_pend0", pend(0), 0);
        chk("x0_total", tot, 1);

        // WAW saturation on x7.
        for (int i = 0; i < 3; i++) begin
            send(0, 0, 7, 0, 0, 1, a);
            q.push_back('{a, 5});
        end
        send(0, 0, 7, 0, 0, 1, a);
        q.push_back('{a + 3, 8});
        chk("waw_ready_low", dec_ready_o, 0);
        step(1);
        wb(7);
        step(2);
        chk("waw_pend7", pend(7), 3);

        // Issue and writeback to x9 in the same cycle.
        send(0, 0, 9, 0, 0, 1, a);
        q.push_back('{a, 8});
        step(1);
        chk("same_pend9_pre", pend(9), 1);
        send(0, 0, 9, 0, 0, 1, a);
        q.push_back('{a, 8});
        wb(9);
        chk("same_pend9", pend(9), 1);

        // Flush while stalled on x4 with two writes outstanding.
        send(0, 0, 4, 0, 0, 1, a);
        q.push_back('{a, 8});
        send(0, 0, 4, 0, 0, 1, a);
        q.push_back('{a, 8});
        step(1);
        chk("flush_pend4_pre", pend(4), 2);
        send(4, 0, 0, 1, 0, 0, a);
        step(1);
        flush_i    = 1'b1;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd4;
        step(1);
        flush_i    = 1'b0;
        wb_valid_i = 1'b0;
        chk("flush_ready", dec_ready_o, 1);
        chk("flush_exe_valid", exe_valid_o, 0);
        chk("flush_pend4", pend(4), 0);
        chk("flush_pend7", pend(7), 0);
        chk("flush_pend9", pend(9), 0);
        chk("flush_stall", stall_cnt_o, 9);
        step(5);
        chk("flush_no_issue", exe_valid_o, 0);

        // Execute back-pressure holds the issue.
        exe_ready_i = 1'b0;
        send(1, 0, 0, 1, 0, 0, a);
        q.push_back('{a + 2, 9});
        step(1);
        chk("hold_valid1", exe_valid_o, 1);
        step(1);
        chk("hold_valid2", exe_valid_o, 1);
        exe_ready_i = 1'b1;
        step(1);
        chk("hold_idle", dec_ready_o, 1);

        // Reset while stalled clears everything, including stall count.
        send(0, 0, 10, 0, 0, 1, a);
        q.push_back('{a, 9});
        step(1);
        send(10, 0, 0, 1, 0, 0, a);
        step(2);
        chk("midrst_stall_pre", stall_cnt_o, 11);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk("midrst_stall", stall_cnt_o, 0);
        chk("midrst_ready", dec_ready_o, 1);
        chk("midrst_pend10", pend(10), 0);
        step(3);
        chk("midrst_no_issue", exe_valid_o, 0);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
